// File: rtl/uart_rx_deserializer_if.sv
// Bus between the UART receive deserializer and its system-side user.
// The serial line plus frame configuration flow into the receiver, and the
// recovered word and its status pulses flow back out.
interface uart_rx_deserializer_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 6
) ();
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [WIDTH-1:0]      P_DATA;
    logic                  Data_valid;
    logic                  Parity_error;
    logic                  Stop_error;

    // Receiver side
    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, Data_valid, Parity_error, Stop_error
    );

    // Line driver / word consumer side
    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, Data_valid, Parity_error, Stop_error
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversamples RX_IN at Prescale clocks per bit,
// resolves each bit by a 3-sample majority vote around mid-bit, and emits the
// parallel word with single-cycle valid / error pulses.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle, waiting for RX_IN low (start edge)
// START  | inside start bit; a high majority means glitch -> IDLE
// DATA   | shifting WIDTH data bits, LSB first
// PARITY | checking the optional parity bit
// STOP   | resolving stop bit; leaves at mid-bit to catch a following start
module uart_rx_deserializer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  Reset,
    uart_rx_deserializer_if.slave bus
);
    localparam int BIT_W = $clog2(WIDTH) + 1;
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q,        state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q,     edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,      bit_cnt_d;
    logic [PRESCALE_W-1:0] presc_q,        presc_d;
    logic                  par_en_q,       par_en_d;
    logic                  par_typ_q,      par_typ_d;
    logic [1:0]            samp_q,         samp_d;
    logic [WIDTH-1:0]      shift_q,        shift_d;
    logic                  par_err_q,      par_err_d;
    logic [WIDTH-1:0]      p_data_q,       p_data_d;
    logic                  data_valid_q,   data_valid_d;
    logic                  parity_error_q, parity_error_d;
    logic                  stop_error_q,   stop_error_d;

    logic [PRESCALE_W-1:0] half;
    logic                  at_s0, at_s1, at_dec, at_end;
    logic                  maj;

    // Sample points derived from the latched prescale; the third sample is
    // the live line value in the decision cycle.
    always_comb begin
        half   = presc_q >> 1;
        at_s0  = (edge_cnt_q == half - ONE);
        at_s1  = (edge_cnt_q == half);
        at_dec = (edge_cnt_q == half + ONE);
        at_end = (edge_cnt_q == presc_q - ONE);
        maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & bus.RX_IN) | (samp_q[1] & bus.RX_IN);
    end

    // Next-state, counters, data path and output pulses
    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        presc_d        = presc_q;
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
        samp_d         = samp_q;
        shift_d        = shift_q;
        par_err_d      = par_err_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        if (state_q != IDLE) begin
            edge_cnt_d = at_end ? '0 : edge_cnt_q + ONE;
            if (at_s0) samp_d[0] = bus.RX_IN;
            if (at_s1) samp_d[1] = bus.RX_IN;
        end

        case (state_q)
            IDLE: begin
                if (!bus.RX_IN) begin
                    // This cycle is edge 0 of the start bit
                    state_d    = START;
                    edge_cnt_d = ONE;
                    bit_cnt_d  = '0;
                    presc_d    = bus.Prescale;
                    par_en_d   = bus.PAR_EN;
                    par_typ_d  = bus.PAR_TYP;
                    par_err_d  = 1'b0;
                end
            end
            START: begin
                if (at_dec && maj) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (at_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (at_dec) shift_d = {maj, shift_q[WIDTH-1:1]};
                if (at_end) begin
                    if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (at_dec) par_err_d = (maj != ((^shift_q) ^ par_typ_q));
                if (at_end) state_d = STOP;
            end
            STOP: begin
                if (at_dec) begin
                    state_d        = IDLE;
                    edge_cnt_d     = '0;
                    stop_error_d   = ~maj;
                    parity_error_d = par_err_q;
                    data_valid_d   = maj & ~par_err_q;
                    if (maj && !par_err_q) p_data_d = shift_q;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q        <= IDLE;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            presc_q        <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            samp_q         <= '0;
            shift_q        <= '0;
            par_err_q      <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            presc_q        <= presc_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            samp_q         <= samp_d;
            shift_q        <= shift_d;
            par_err_q      <= par_err_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign bus.P_DATA       = p_data_q;
    assign bus.Data_valid   = data_valid_q;
    assign bus.Parity_error = parity_error_q;
    assign bus.Stop_error   = stop_error_q;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for the UART receive deserializer.
module tb_uart_rx_deserializer;
    localparam int W  = 8;
    localparam int PW = 6;

    logic CLK = 1'b0;
    logic Reset;

    uart_rx_deserializer_if #(.WIDTH(W), .PRESCALE_W(PW)) bus ();

    uart_rx_deserializer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge
    int         n_dv = 0, n_pe = 0, n_se = 0;
    int         dv_cyc = -1;
    logic [7:0] last_word = 8'h00, prev_word = 8'h00;
    always @(negedge CLK) begin
        if (bus.Data_valid === 1'b1) begin
            n_dv++;
            dv_cyc    = cyc;
            prev_word = last_word;
            last_word = bus.P_DATA;
        end
        if (bus.Parity_error === 1'b1) n_pe++;
        if (bus.Stop_error === 1'b1)   n_se++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int p, input int g, output int t_first);
        for (int e = 0; e < p; e++) begin
            @(negedge CLK);
            if (e == 0) t_first = cyc;
            bus.RX_IN = (e == g) ? ~b : b;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic pbit, input logic sbit, input int gbit,
                              output int t0);
        int tmp;
        drive_bit(1'b0, p, -1, t0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, (i == gbit) ? p / 2 : -1, tmp);
        if (pen) drive_bit(pbit, p, -1, tmp);
        drive_bit(sbit, p, -1, tmp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            bus.RX_IN = 1'b1;
        end
    endtask

    task automatic config_line(input int p, input logic pen, input logic ptyp);
        bus.Prescale = p[PW-1:0];
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, tmp;
        int b_dv, b_pe, b_se;

        Reset      = 1'b0;
        bus.RX_IN  = 1'b1;
        config_line(8, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        chk("rst_p_data", 32'(bus.P_DATA), 32'h00);
        chk("rst_dv",     32'(bus.Data_valid), 0);
        chk("rst_pe",     32'(bus.Parity_error), 0);
        chk("rst_se",     32'(bus.Stop_error), 0);
        Reset = 1'b1;
        idle(4);

        // P=8, no parity, 0xA5
        b_dv = n_dv; b_pe = n_pe; b_se = n_se;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, t0);
        idle(10);
        chk("a5_dv_cnt",  32'(n_dv - b_dv), 1);
        chk("a5_latency", 32'(dv_cyc - t0), 78);
        chk("a5_word",    32'(last_word), 32'hA5);
        chk("a5_pe_cnt",  32'(n_pe - b_pe), 0);
        chk("a5_se_cnt",  32'(n_se - b_se), 0);

        // P=8, even parity latency, 0xA5 has four ones -> parity bit 0
        config_line(8, 1'b1, 1'b0);
        b_dv = n_dv; b_pe = n_pe;
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, -1, t0);
        idle(10);
        chk("par_dv_cnt",  32'(n_dv - b_dv), 1);
        chk("par_latency", 32'(dv_cyc - t0), 86);
        chk("par_pe_cnt",  32'(n_pe - b_pe), 0);

        // P=16, odd parity, 0x3C good then bad parity
        config_line(16, 1'b1, 1'b1);
        b_dv = n_dv; b_pe = n_pe;
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1, t0);
        idle(10);
        chk("odd_ok_dv",   32'(n_dv - b_dv), 1);
        chk("odd_ok_word", 32'(bus.P_DATA), 32'h3C);
        chk("odd_ok_pe",   32'(n_pe - b_pe), 0);
        b_dv = n_dv; b_pe = n_pe;
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1, t0);
        idle(10);
        chk("odd_bad_dv",  32'(n_dv - b_dv), 0);
        chk("odd_bad_pe",  32'(n_pe - b_pe), 1);
        chk("odd_bad_hold", 32'(bus.P_DATA), 32'h3C);
        // 0x3D has five ones, odd parity bit should be 0
        b_dv = n_dv; b_pe = n_pe;
        send_frame(8'h3D, 16, 1'b1, 1'b1, 1'b1, -1, t0);
        idle(10);
        chk("odd_3d_pe",   32'(n_pe - b_pe), 1);
        chk("odd_3d_hold", 32'(bus.P_DATA), 32'h3C);

        // Start glitch: low two cycles then high
        config_line(8, 1'b0, 1'b0);
        b_dv = n_dv; b_pe = n_pe; b_se = n_se;
        @(negedge CLK); bus.RX_IN = 1'b0;
        @(negedge CLK); bus.RX_IN = 1'b0;
        idle(16);
        chk("glitch_dv", 32'(n_dv - b_dv), 0);
        chk("glitch_pe", 32'(n_pe - b_pe), 0);
        chk("glitch_se", 32'(n_se - b_se), 0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1, t0);
        idle(10);
        chk("post_glitch_word", 32'(bus.P_DATA), 32'h5A);
        chk("post_glitch_dv",   32'(n_dv - b_dv), 1);

        // Stop bit 0 on 0xFF
        b_dv = n_dv; b_pe = n_pe; b_se = n_se;
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, -1, t0);
        idle(20);
        chk("stop_se",   32'(n_se - b_se), 1);
        chk("stop_dv",   32'(n_dv - b_dv), 0);
        chk("stop_pe",   32'(n_pe - b_pe), 0);
        chk("stop_hold", 32'(bus.P_DATA), 32'h5A);

        // Mid-sample glitch on data bit 3 of 0x96
        b_dv = n_dv;
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 3, t0);
        idle(10);
        chk("maj_dv",   32'(n_dv - b_dv), 1);
        chk("maj_word", 32'(bus.P_DATA), 32'h96);

        // Back-to-back 0x12, 0x34 at P=32, even parity
        config_line(32, 1'b1, 1'b0);
        b_dv = n_dv; b_pe = n_pe; b_se = n_se;
        send_frame(8'h12, 32, 1'b1, 1'b0, 1'b1, -1, t0);
        send_frame(8'h34, 32, 1'b1, 1'b1, 1'b1, -1, t0);
        idle(10);
        chk("b2b_dv",    32'(n_dv - b_dv), 2);
        chk("b2b_first", 32'(prev_word), 32'h12);
        chk("b2b_last",  32'(last_word), 32'h34);
        chk("b2b_pe",    32'(n_pe - b_pe), 0);
        chk("b2b_se",    32'(n_se - b_se), 0);

        // Reset during data bit 4 of 0x81
        config_line(8, 1'b0, 1'b0);
        b_dv = n_dv; b_pe = n_pe; b_se = n_se;
        drive_bit(1'b0, 8, -1, t0);
        for (int i = 0; i < 4; i++) drive_bit(tmp[0] | (i == 0), 8, -1, tmp);
        drive_bit(1'b0, 3, -1, tmp);
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        chk("mid_rst_p_data", 32'(bus.P_DATA), 32'h00);
        chk("mid_rst_dv",     32'(bus.Data_valid), 0);
        chk("mid_rst_pe",     32'(bus.Parity_error), 0);
        chk("mid_rst_se",     32'(bus.Stop_error), 0);
        bus.RX_IN = 1'b1;
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        idle(40);
        chk("mid_rst_no_dv", 32'(n_dv - b_dv), 0);
        chk("mid_rst_no_se", 32'(n_se - b_se), 0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1, t0);
        idle(10);
        chk("post_rst_word", 32'(bus.P_DATA), 32'h81);
        chk("post_rst_dv",   32'(n_dv - b_dv), 1);
        chk("post_rst_lat",  32'(dv_cyc - t0), 78);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
UART receive path. Takes the asynchronous-format serial line and oversamples it at Prescale clocks per bit, using a 3-sample majority vote per bit. It recovers start / WIDTH data bits (LSB first) / optional parity / stop, and presents the parallel word with a one-cycle valid pulse. It is the receive counterpart of the TX serializer and drives the same system-side data bus.

Parameters:
- WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the Prescale input and of the internal edge counter.

Ports:
- CLK  input  1  system clock; RX_IN is already synchronized to it upstream.
- Reset  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line; idle high.
- Prescale  input  PRESCALE_W  clocks per bit; legal values are even and >= 8 (8, 16, 32 required).
- PAR_EN  input  1  1 = parity bit present after the data bits.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  WIDTH  last received word.
- Data_valid  output  1  one-cycle pulse when a good frame is received.
- Parity_error  output  1  one-cycle pulse on parity mismatch.
- Stop_error  output  1  one-cycle pulse when the stop bit is sampled 0.

Behaviour:
- Reset (async, Reset=0): state=IDLE, all counters 0, P_DATA=0, Data_valid=0, Parity_error=0, Stop_error=0. Asserting Reset mid-frame aborts the frame and produces no pulses.
- Frame configuration (Prescale, PAR_EN, PAR_TYP) is latched in the IDLE->START cycle. Changes during a frame are ignored.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: the first cycle with RX_IN=0 becomes edge_cnt=0 of the start bit; the state moves to START.
- Per-bit timing:
  - edge_cnt counts 0..P-1, where P is the latched Prescale.
  - RX_IN is sampled at edge_cnt = P/2-1, P/2, P/2+1.
  - The bit value is the majority of the three samples, resolved at the end of edge_cnt = P/2+1.
  - The state advances and edge_cnt wraps to 0 after edge_cnt = P-1.
- START: if the resolved start bit is 1 (glitch), return to IDLE at the decision point with no flags. Otherwise continue to DATA.
- DATA:
  - bit_cnt counts 0..WIDTH-1; each resolved bit is shifted into a shift register so the first bit received lands in P_DATA[0].
  - After the last bit, go to PARITY if PAR_EN=1, else to STOP.
- PARITY: expected bit = XOR of the data bits, inverted when PAR_TYP=1. A mismatch is recorded internally.
- STOP: the stop bit is resolved at edge_cnt = P/2+1. The FSM returns to IDLE at that decision point, not after P-1, so a start bit directly following is caught.
- Output pulses, registered, all in the cycle after the stop decision, each for exactly 1 cycle:
  - Stop_error = (stop bit == 0).
  - Parity_error = recorded parity mismatch (PAR_EN=1 only).
  - Data_valid = !Stop_error && !Parity_error.
  - P_DATA updates only when Data_valid pulses and otherwise holds the previous good word.
- Both errors may pulse in the same cycle.
- Back-to-back frames are supported: a start edge may arrive from IDLE one cycle after the stop decision.
- Latency: with P=8 and start low first seen at cycle 0:
  - no parity: pulses in cycle 8*(WIDTH+1)+6 = 78;
  - with parity: cycle 86.
- Counter widths: edge_cnt is PRESCALE_W bits; bit_cnt is $clog2(WIDTH)+1 bits. No wrap beyond the listed ranges.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 (LSB first, stop=1) -> P_DATA=0xA5; Data_valid=1 in cycle 78 only; both error flags stay 0.
- Prescale=16, PAR_EN=1, PAR_TYP=1, frame 0x3C with parity bit 1 -> P_DATA=0x3C, Data_valid pulses once. Repeat with parity bit 0 -> Parity_error pulses, Data_valid=0, P_DATA stays 0x3C.
- RX_IN low for 2 cycles then high (Prescale=8) -> FSM returns to IDLE, no pulses. A valid 0x5A frame that follows is received correctly.
- Prescale=8, frame 0xFF with stop bit 0 -> Stop_error pulses, Data_valid=0, P_DATA unchanged. Single-cycle inverted glitch at the P/2 sample of data bit 3 -> majority vote still yields the correct word.
- Two frames 0x12, 0x34 back-to-back with zero idle time (Prescale=32, even parity) -> two Data_valid pulses, P_DATA 0x12 then 0x34, no errors.
- Reset pulsed low during data bit 4 -> all outputs 0 immediately, FSM in IDLE, no pulses. The next full frame (0x81) is received correctly.
